// File: rtl/nes_mem_sched.sv
// nes_mem_sched: memory-slot scheduler between the ROM loader, the NES core and SDRAM.
// Owns the 4-phase NES clock-enable counter, buffers loader bytes in a small FIFO
// and issues them one per slot, and muxes the SDRAM port between loader and CPU/PPU.
// Optional statistics counters are enabled by defining NES_MEM_SCHED_STATS_EN.
module nes_mem_sched #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 22
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          hold,
    input  logic          downloading,
    input  logic          ld_wr,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_data,
    output logic          ld_full,
    output logic          ld_ovf,
    input  logic [AW-1:0] cpu_addr,
    input  logic          cpu_wr,
    input  logic          cpu_rd,
    input  logic          ppu_rd,
    input  logic [7:0]    cpu_dout,
    output logic [1:0]    nes_ce,
    output logic          run_nes,
    output logic          nes_reset,
    output logic          sd_clkref,
    output logic [AW-1:0] sd_addr,
    output logic [7:0]    sd_din,
    output logic          sd_we,
    output logic          sd_oeA,
    output logic          sd_oeB
`ifdef NES_MEM_SCHED_STATS_EN
    ,
    output logic [23:0]   ld_count,
    output logic [7:0]    ovf_count
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned EW = AW + 8;

    typedef enum logic [1:0] {S_HOLD, S_RUN, S_LOAD, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [1:0]    ce_q, ce_d;
    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_act_q, wr_act_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    din_q, din_d;
    logic          ovf_q, ovf_d;
    logic          dl_q, dl_d;

    logic          boundary, loading, empty, full;
    logic          pop, bypass, issue, push, drop, dl_rise;
    logic [EW-1:0] head;

    // State and datapath registers; reset aborts any in-flight write and empties the FIFO
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= S_HOLD;
            ce_q     <= 2'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            wr_act_q <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            ovf_q    <= 1'b0;
            dl_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ce_q     <= ce_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            wr_act_q <= wr_act_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            ovf_q    <= ovf_d;
            dl_q     <= dl_d;
        end
    end

    // FIFO storage; contents are don't-care while the count is zero
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {ld_addr, ld_data};
        end
    end

    // Phase counter, FIFO bookkeeping and loader issue; an empty FIFO at a slot boundary
    // forwards a same-cycle byte directly so the ld_wr -> sd_we latency stays within 1..4 clk
    always_comb begin
        boundary = (ce_q == 2'd3);
        loading  = (state_q == S_LOAD) || (state_q == S_DRAIN);
        empty    = (cnt_q == '0);
        full     = (cnt_q == CW'(DEPTH));
        head     = mem_q[rd_ptr_q];
        pop      = boundary && loading && !empty;
        bypass   = boundary && loading && empty && ld_wr;
        issue    = pop || bypass;
        push     = ld_wr && !bypass && (!full || pop);
        drop     = ld_wr && full && !pop;
        dl_rise  = downloading && !dl_q;

        ce_d     = ce_q + 2'd1;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
        wr_act_d = boundary ? issue : wr_act_q;
        dl_d     = downloading;

        addr_d = addr_q;
        din_d  = din_q;
        if (state_q == S_RUN) begin
            addr_d = cpu_addr;
            din_d  = cpu_dout;
        end else if (pop) begin
            addr_d = head[EW-1:8];
            din_d  = head[7:0];
        end else if (bypass) begin
            addr_d = ld_addr;
            din_d  = ld_data;
        end

        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (dl_rise) begin
            ovf_d = 1'b0;
        end
    end

    // Next-state logic, evaluated only at slot boundaries
    always_comb begin
        state_d = state_q;
        if (boundary) begin
            case (state_q)
                S_HOLD: begin
                    if (downloading) state_d = S_LOAD;
                    else if (!hold)  state_d = S_RUN;
                end
                S_RUN: begin
                    if (downloading) state_d = S_LOAD;
                    else if (hold)   state_d = S_HOLD;
                end
                S_LOAD: begin
                    if (!downloading) state_d = S_DRAIN;
                end
                S_DRAIN: begin
                    if (downloading)          state_d = S_LOAD;
                    else if (empty && !bypass) state_d = S_HOLD;
                end
                default: state_d = S_HOLD;
            endcase
        end
    end

    // Output mux: CPU/PPU passthrough in RUN, registered loader write otherwise
    always_comb begin
        sd_addr   = addr_q;
        sd_din    = din_q;
        sd_we     = 1'b0;
        sd_oeA    = 1'b0;
        sd_oeB    = 1'b0;
        case (state_q)
            S_RUN: begin
                sd_addr = cpu_addr;
                sd_din  = cpu_dout;
                sd_we   = cpu_wr;
                sd_oeA  = cpu_rd;
                sd_oeB  = ppu_rd;
            end
            S_LOAD, S_DRAIN: sd_we = wr_act_q;
            default: ;
        endcase
        nes_ce    = ce_q;
        sd_clkref = ce_q[1];
        run_nes   = boundary && (state_q == S_RUN) && !hold;
        nes_reset = (state_q == S_RUN) ? hold : 1'b1;
        ld_full   = full;
        ld_ovf    = ovf_q;
    end

`ifdef NES_MEM_SCHED_STATS_EN
    logic [23:0] ld_count_q, ld_count_d;
    logic [7:0]  ovf_count_q, ovf_count_d;

    // Saturating issued/dropped byte counters, cleared when a new download starts
    always_comb begin
        ld_count_d  = ld_count_q;
        ovf_count_d = ovf_count_q;
        if (dl_rise) begin
            ld_count_d  = '0;
            ovf_count_d = '0;
        end else begin
            if (issue && !(&ld_count_q)) ld_count_d  = ld_count_q + 24'd1;
            if (drop && !(&ovf_count_q)) ovf_count_d = ovf_count_q + 8'd1;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ld_count_q  <= '0;
            ovf_count_q <= '0;
        end else begin
            ld_count_q  <= ld_count_d;
            ovf_count_q <= ovf_count_d;
        end
    end

    assign ld_count  = ld_count_q;
    assign ovf_count = ovf_count_q;
`endif

endmodule
